// File: rtl/argon_mem_pkg.sv
// argon_mem_pkg: shared types, mask encodings and alignment helpers for the memory port arbiter
package argon_mem_pkg;

  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} size_e;

  localparam logic [2:0] RD_MASK_IDLE = 3'b000;
  localparam logic [2:0] RD_MASK_BYTE = 3'b001;
  localparam logic [2:0] RD_MASK_HALF = 3'b011;
  localparam logic [2:0] RD_MASK_WORD = 3'b111;

  localparam logic [1:0] WR_MASK_NONE = 2'b00;
  localparam logic [1:0] WR_MASK_BYTE = 2'b01;
  localparam logic [1:0] WR_MASK_HALF = 2'b10;
  localparam logic [1:0] WR_MASK_WORD = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_e;

  // Size 11 has no legal encoding, so it is treated like a misaligned access.
  function automatic logic bad_align(logic [1:0] size, logic [1:0] a);
    return size == 2'b11 || (size == SIZE_HALF && a[0]) || (size == SIZE_WORD && a != 2'b00);
  endfunction

  function automatic logic [2:0] rd_mask(logic [1:0] size);
    return size == SIZE_BYTE ? RD_MASK_BYTE : size == SIZE_HALF ? RD_MASK_HALF : RD_MASK_WORD;
  endfunction

  function automatic logic [1:0] wr_mask(logic [1:0] size);
    return size == SIZE_BYTE ? WR_MASK_BYTE : size == SIZE_HALF ? WR_MASK_HALF : WR_MASK_WORD;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: pending-request bits for IF and D with round-robin selection
module mem_rr_pick
  import argon_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_if,
  input  logic       set_d,
  input  logic       take,
  output logic [1:0] pending,
  output logic       grant_valid,
  output req_e       grant_id
);

  logic [1:0] pend_q, pend_d;
  req_e       last_q, last_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_valid = |pend_q;
    grant_id = (&pend_q) ? (last_q == REQ_IF ? REQ_D : REQ_IF) : (pend_q[REQ_D] ? REQ_D : REQ_IF);
    pend_d = pend_q | {set_d, set_if};
    last_d = last_q;
    if (take) begin
      pend_d[grant_id] = 1'b0;
      last_d = grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      last_q <= REQ_IF;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and data access
module mem_port_arbiter
  import argon_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic              o_if_err,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [1:0]        i_d_size,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_done,
  output logic              o_d_err,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_rd_mask,
  output logic [1:0]        o_mem_wr_mask,
  input  logic [DATA_W-1:0] i_mem_data
);

  logic [ADDR_W-1:0] if_addr_q, if_addr_d, d_addr_q, d_addr_d, mem_addr_q, mem_addr_d, sel_addr;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d, mem_wdata_q, mem_wdata_d, fin_rdata;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]        d_size_q, d_size_d, wr_mask_q, wr_mask_d, sel_size, pending;
  logic [2:0]        rd_mask_q, rd_mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              d_we_q, d_we_d, sel_we, sel_bad, busy, acc_if, acc_d, take, fin, fin_err;
  logic              if_done_q, if_done_d, if_err_q, if_err_d, d_done_q, d_done_d, d_err_q, d_err_d;
  logic              grant_valid;
  req_e              grant_id, owner_q, owner_d;
  state_e            state_q, state_d;

  mem_rr_pick u_pick (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .set_if     (acc_if),
    .set_d      (acc_d),
    .take       (take),
    .pending    (pending),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    busy = state_q != ST_IDLE;
    acc_if = i_if_req & ~pending[REQ_IF] & ~(busy & owner_q == REQ_IF);
    acc_d = i_d_req & ~pending[REQ_D] & ~(busy & owner_q == REQ_D);
    if_addr_d = acc_if ? i_if_addr : if_addr_q;
    d_addr_d = acc_d ? i_d_addr : d_addr_q;
    d_we_d = acc_d ? i_d_we : d_we_q;
    d_size_d = acc_d ? i_d_size : d_size_q;
    d_wdata_d = acc_d ? i_d_wdata : d_wdata_q;
    sel_addr = grant_id == REQ_D ? d_addr_q : if_addr_q;
    sel_size = grant_id == REQ_D ? d_size_q : SIZE_WORD;
    sel_we = grant_id == REQ_D & d_we_q;
    sel_bad = bad_align(sel_size, sel_addr[1:0]);
    state_d = state_q;
    cnt_d = cnt_q;
    owner_d = owner_q;
    take = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_mask_d = rd_mask_q;
    wr_mask_d = wr_mask_q;
    fin = 1'b0;
    fin_err = 1'b0;
    fin_rdata = '0;
    if (state_q == ST_IDLE && grant_valid) begin
      take = 1'b1;
      owner_d = grant_id;
      if (sel_bad) begin
        state_d = ST_DONE;
        fin = 1'b1;
        fin_err = 1'b1;
      end else begin
        state_d = ST_ACCESS;
        cnt_d = 4'(MEM_LATENCY - 1);
        mem_addr_d = sel_addr;
        mem_wdata_d = sel_we ? d_wdata_q : '0;
        rd_mask_d = sel_we ? RD_MASK_IDLE : rd_mask(sel_size);
        wr_mask_d = sel_we ? wr_mask(sel_size) : WR_MASK_NONE;
      end
    end else if (state_q == ST_ACCESS) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        state_d = ST_DONE;
        fin = 1'b1;
        fin_rdata = wr_mask_q != WR_MASK_NONE ? '0 : i_mem_data;
        mem_addr_d = '0;
        mem_wdata_d = '0;
        rd_mask_d = RD_MASK_IDLE;
        wr_mask_d = WR_MASK_NONE;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
    if_done_d = fin & owner_d == REQ_IF;
    d_done_d = fin & owner_d == REQ_D;
    if_err_d = fin_err & owner_d == REQ_IF;
    d_err_d = fin_err & owner_d == REQ_D;
    if_rdata_d = owner_d == REQ_IF ? fin_rdata : '0;
    d_rdata_d = owner_d == REQ_D ? fin_rdata : '0;
  end

  // Reset also abandons an in-flight access: state, outputs and latches all clear at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if_addr_q <= '0;
      d_addr_q <= '0;
      d_we_q <= 1'b0;
      d_size_q <= '0;
      d_wdata_q <= '0;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      owner_q <= REQ_IF;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rd_mask_q <= RD_MASK_IDLE;
      wr_mask_q <= WR_MASK_NONE;
      if_done_q <= 1'b0;
      if_err_q <= 1'b0;
      if_rdata_q <= '0;
      d_done_q <= 1'b0;
      d_err_q <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      if_addr_q <= if_addr_d;
      d_addr_q <= d_addr_d;
      d_we_q <= d_we_d;
      d_size_q <= d_size_d;
      d_wdata_q <= d_wdata_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_mask_q <= rd_mask_d;
      wr_mask_q <= wr_mask_d;
      if_done_q <= if_done_d;
      if_err_q <= if_err_d;
      if_rdata_q <= if_rdata_d;
      d_done_q <= d_done_d;
      d_err_q <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign o_if_done = if_done_q;
  assign o_if_err = if_err_q;
  assign o_if_rdata = if_rdata_q;
  assign o_d_done = d_done_q;
  assign o_d_err = d_err_q;
  assign o_d_rdata = d_rdata_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_rd_mask = rd_mask_q;
  assign o_mem_wr_mask = wr_mask_q;

endmodule
